ps2_kbd_ctrl: RTL and testbench

Keyboard controller between the PS/2 scancode receiver and the CPU bus. It takes raw scancode bytes from the receiver and folds the E0/F0 prefixes into single key events. Events are queued in a small FIFO. The CPU reads events and status through an active-low read strobe. Each completed data read pops one event, so software never loses keys between polls.

---
 rtl/kbd_pkg.sv | 35 +++
 rtl/ps2_kbd_ctrl_if.sv | 27 ++
 rtl/kbd_evt_fifo.sv | 71 +++++++
 rtl/ps2_kbd_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types and constants for the PS/2 keyboard controller
//
// Purpose : prefix FSM state encoding, scancode prefix constants and the
//           key event word layout used by ps2_kbd_ctrl and kbd_evt_fifo.
// Ports   : none (package).
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } kbd_state_t;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_BAT_ERR = 8'hFC;

    // Event word: [9] brk, [8] ext, [7:0] code
    localparam int EVT_W   = 10;
    localparam int EVT_BRK = 9;
    localparam int EVT_EXT = 8;

    function automatic logic [EVT_W-1:0] make_evt(input logic brk, input logic ext,
                                                  input logic [7:0] code);
        logic [EVT_W-1:0] e;
        e          = '0;
        e[EVT_BRK] = brk;
        e[EVT_EXT] = ext;
        e[7:0]     = code;
        return e;
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// rtl/ps2_kbd_ctrl_if.sv - receiver/CPU side signal bundle of the keyboard controller
//
// Purpose : groups the scancode input, the CPU read port and the status flags.
// Signals : code_in[7:0], code_valid   scancode byte and its one-cycle strobe
//           cpu_rdn, cpu_sel           active-low read strobe, register select
//           cpu_dout[15:0]             read data
//           data_ready, overflow       FIFO not empty, sticky drop flag
// Modports: master = receiver/CPU side, slave = controller.
interface ps2_kbd_ctrl_if;
    logic [7:0]  code_in;
    logic        code_valid;
    logic        cpu_rdn;
    logic        cpu_sel;
    logic [15:0] cpu_dout;
    logic        data_ready;
    logic        overflow;

    modport master (
        output code_in, code_valid, cpu_rdn, cpu_sel,
        input  cpu_dout, data_ready, overflow
    );

    modport slave (
        input  code_in, code_valid, cpu_rdn, cpu_sel,
        output cpu_dout, data_ready, overflow
    );
endinterface

// File: rtl/kbd_evt_fifo.sv
// rtl/kbd_evt_fifo.sv - DEPTH x EVT_W synchronous event FIFO, first-word fall-through
//
// Purpose : stores key events; the head entry is visible without a pop.
// Ports   : fclk, rst        clock, asynchronous active-low reset
//           i_push, i_data   write request and event word
//           i_pop            read request (ignored when empty)
//           o_head           entry at the read pointer
//           o_full, o_empty  occupancy flags
//           o_count          number of stored entries (0..DEPTH)
import kbd_pkg::*;

module kbd_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [EVT_W-1:0] i_data,
    input  logic             i_pop,
    output logic [EVT_W-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [EVT_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge fclk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 scancode to key event controller with CPU read port
//
// Purpose : folds E0/F0 prefixes into key events, queues them and serves
//           data/status reads; each finished data read pops one event.
// Ports   : fclk  system clock
//           rst   asynchronous active-low reset
//           bus   ps2_kbd_ctrl_if.slave (code_in/code_valid, cpu_rdn/cpu_sel,
//                 cpu_dout, data_ready, overflow)
// Options : TYPEMATIC_FILTER_EN suppresses repeated makes of the last key
//           until its break is seen.
import kbd_pkg::*;

module ps2_kbd_ctrl #(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic fclk,
    input  logic rst,
    ps2_kbd_ctrl_if.slave bus
);
    kbd_state_t       r_state;
    kbd_state_t       w_nxt_state;
    logic             w_push_req;
    logic             w_push;
    logic [EVT_W-1:0] w_evt;

    logic r_rdn_s1;
    logic r_rdn_s2;
    logic r_rdn_d;
    logic r_sel_q;
    logic r_overflow;
    logic w_rd_start;
    logic w_rd_done;
    logic w_pop;
    logic w_drop;

    logic [EVT_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;

    // Prefix decode; only consulted on code_valid cycles
    always_comb begin
        w_nxt_state = r_state;
        w_push_req  = 1'b0;
        w_evt       = '0;
        if (bus.code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.code_in == SC_EXT) begin
                        w_nxt_state = ST_EXT;
                    end else if (bus.code_in == SC_BRK) begin
                        w_nxt_state = ST_BRK;
                    end else if (bus.code_in != SC_BAT_OK && bus.code_in != SC_BAT_ERR) begin
                        w_push_req = 1'b1;
                        w_evt      = make_evt(1'b0, 1'b0, bus.code_in);
                    end
                end
                ST_EXT: begin
                    if (bus.code_in == SC_BRK) begin
                        w_nxt_state = ST_EXTBRK;
                    end else if (bus.code_in == SC_EXT) begin
                        w_nxt_state = ST_EXT;
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_push_req  = 1'b1;
                        w_evt       = make_evt(1'b0, 1'b1, bus.code_in);
                    end
                end
                ST_BRK: begin
                    w_nxt_state = ST_IDLE;
                    if (bus.code_in != SC_EXT && bus.code_in != SC_BRK) begin
                        w_push_req = 1'b1;
                        w_evt      = make_evt(1'b1, 1'b0, bus.code_in);
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    if (bus.code_in != SC_EXT && bus.code_in != SC_BRK) begin
                        w_push_req = 1'b1;
                        w_evt      = make_evt(1'b1, 1'b1, bus.code_in);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    logic [8:0] r_tm_key;
    logic       r_tm_vld;
    logic       w_tm_match;
    logic       w_suppress;

    assign w_tm_match = r_tm_vld & (r_tm_key == w_evt[8:0]);
    assign w_suppress = w_push_req & ~w_evt[EVT_BRK] & w_tm_match;
    assign w_push     = w_push_req & ~w_suppress;

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_tm_key <= '0;
            r_tm_vld <= 1'b0;
        end else if (w_push_req) begin
            if (!w_evt[EVT_BRK]) begin
                r_tm_key <= w_evt[8:0];
                r_tm_vld <= 1'b1;
            end else if (w_tm_match) begin
                r_tm_vld <= 1'b0;
            end
        end
    end
`else
    assign w_push = w_push_req;
`endif

    // cpu_rdn is asynchronous: two sync flops, then a delayed copy for edges.
    // The rising-edge pulse acts on the third fclk edge after the pin rises.
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_rdn_s1 <= 1'b1;
            r_rdn_s2 <= 1'b1;
            r_rdn_d  <= 1'b1;
        end else begin
            r_rdn_s1 <= bus.cpu_rdn;
            r_rdn_s2 <= r_rdn_s1;
            r_rdn_d  <= r_rdn_s2;
        end
    end

    assign w_rd_start = ~r_rdn_s2 & r_rdn_d;
    assign w_rd_done  = r_rdn_s2 & ~r_rdn_d;

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_sel_q <= 1'b0;
        end else if (w_rd_start) begin
            r_sel_q <= bus.cpu_sel;
        end
    end

    assign w_pop  = w_rd_done & ~r_sel_q & ~w_empty;
    assign w_drop = w_push & w_full & ~w_pop;

    // A drop in the same cycle as a status-read clear wins
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_rd_done && r_sel_q) begin
            r_overflow <= 1'b0;
        end
    end

    kbd_evt_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .fclk    (fclk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        bus.cpu_dout = '0;
        if (bus.cpu_sel) begin
            bus.cpu_dout[15:8] = {{(8-CW){1'b0}}, w_count};
            bus.cpu_dout[2]    = r_overflow;
            bus.cpu_dout[1]    = w_full;
            bus.cpu_dout[0]    = ~w_empty;
        end else if (!w_empty) begin
            bus.cpu_dout[EVT_W-1:0] = w_head;
        end
    end

    assign bus.data_ready = ~w_empty;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - directed self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;
    logic fclk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ps2_kbd_ctrl_if u_if ();

    ps2_kbd_ctrl #(.DEPTH(8)) dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (u_if.slave)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge fclk);
        u_if.code_in    = b;
        u_if.code_valid = 1'b1;
        @(negedge fclk);
        u_if.code_valid = 1'b0;
    endtask

    task automatic cpu_read(input logic sel, output logic [15:0] d);
        @(negedge fclk);
        u_if.cpu_sel = sel;
        u_if.cpu_rdn = 1'b0;
        repeat (4) @(negedge fclk);
        d = u_if.cpu_dout;
        u_if.cpu_rdn = 1'b1;
        repeat (4) @(negedge fclk);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        n_checks++;
        if (u_if.data_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_data_ready got %b want 0", u_if.data_ready);
        end
        n_checks++;
        if (u_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow got %b want 0", u_if.overflow);
        end
        cpu_read(1'b1, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fail++; $display("FAIL reset_status got %h want 0000", d);
        end
        cpu_read(1'b0, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fail++; $display("FAIL reset_empty_data got %h want 0000", d);
        end
    endtask

    task automatic test_make_break();
        logic [15:0] d;
        send_byte(8'h1C);
        n_checks++;
        if (u_if.data_ready !== 1'b1) begin
            n_fail++; $display("FAIL mb_data_ready got %b want 1", u_if.data_ready);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        cpu_read(1'b0, d);
        n_checks++;
        if (d !== 16'h001C) begin
            n_fail++; $display("FAIL mb_make got %h want 001c", d);
        end
        cpu_read(1'b0, d);
        n_checks++;
        if (d !== 16'h021C) begin
            n_fail++; $display("FAIL mb_break got %h want 021c", d);
        end
        n_checks++;
        if (u_if.data_ready !== 1'b0) begin
            n_fail++; $display("FAIL mb_drained got %b want 0", u_if.data_ready);
        end
    endtask

    task automatic test_ext_break();
        logic [15:0] d;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        cpu_read(1'b1, d);
        n_checks++;
        if (d !== 16'h0101) begin
            n_fail++; $display("FAIL extbrk_status got %h want 0101", d);
        end
        cpu_read(1'b0, d);
        n_checks++;
        if (d !== 16'h0375) begin
            n_fail++; $display("FAIL extbrk_event got %h want 0375", d);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        n_checks++;
        if (u_if.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_flag got %b want 1", u_if.overflow);
        end
        cpu_read(1'b1, d);
        n_checks++;
        if (d !== 16'h0807) begin
            n_fail++; $display("FAIL ovf_status got %h want 0807", d);
        end
        n_checks++;
        if (u_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_cleared got %b want 0", u_if.overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            cpu_read(1'b0, d);
            n_checks++;
            if (d !== 16'(i)) begin
                n_fail++; $display("FAIL ovf_entry%0d got %h want %h", i, d, 16'(i));
            end
        end
        n_checks++;
        if (u_if.data_ready !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drained got %b want 0", u_if.data_ready);
        end
    endtask

    // Data read whose read-done pulse coincides with a code_valid byte
    task automatic read_with_push(input logic [7:0] b, output logic [15:0] d);
        @(negedge fclk);
        u_if.cpu_sel = 1'b0;
        u_if.cpu_rdn = 1'b0;
        repeat (4) @(negedge fclk);
        d = u_if.cpu_dout;
        u_if.cpu_rdn = 1'b1;
        repeat (2) @(negedge fclk);
        u_if.code_in    = b;
        u_if.code_valid = 1'b1;
        @(negedge fclk);
        u_if.code_valid = 1'b0;
        repeat (2) @(negedge fclk);
    endtask

    task automatic test_full_pop_push();
        logic [15:0] d;
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
        read_with_push(8'h19, d);
        n_checks++;
        if (d !== 16'h0011) begin
            n_fail++; $display("FAIL fpp_head got %h want 0011", d);
        end
        n_checks++;
        if (u_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL fpp_overflow got %b want 0", u_if.overflow);
        end
        cpu_read(1'b1, d);
        n_checks++;
        if (d !== 16'h0803) begin
            n_fail++; $display("FAIL fpp_status got %h want 0803", d);
        end
        for (int i = 0; i < 8; i++) begin
            cpu_read(1'b0, d);
            n_checks++;
            if (d !== 16'h0012 + 16'(i)) begin
                n_fail++; $display("FAIL fpp_entry%0d got %h want %h", i, d, 16'h0012 + 16'(i));
            end
        end
    endtask

    task automatic test_empty_pop_push();
        logic [15:0] d;
        read_with_push(8'h2B, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fail++; $display("FAIL epp_empty_read got %h want 0000", d);
        end
        cpu_read(1'b1, d);
        n_checks++;
        if (d !== 16'h0101) begin
            n_fail++; $display("FAIL epp_status got %h want 0101", d);
        end
        cpu_read(1'b0, d);
        n_checks++;
        if (d !== 16'h002B) begin
            n_fail++; $display("FAIL epp_event got %h want 002b", d);
        end
    endtask

    task automatic test_prefix_discard();
        logic [15:0] d;
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'hAA);
        send_byte(8'hFC);
        n_checks++;
        if (u_if.data_ready !== 1'b0) begin
            n_fail++; $display("FAIL pd_no_push got %b want 0", u_if.data_ready);
        end
        send_byte(8'h3A);
        cpu_read(1'b0, d);
        n_checks++;
        if (d !== 16'h003A) begin
            n_fail++; $display("FAIL pd_idle_after got %h want 003a", d);
        end
    endtask

    task automatic test_reset_mid_prefix();
        logic [15:0] d;
        send_byte(8'hE0);
        @(negedge fclk);
        rst = 1'b0;
        @(negedge fclk);
        rst = 1'b1;
        send_byte(8'h6B);
        cpu_read(1'b0, d);
        n_checks++;
        if (d !== 16'h006B) begin
            n_fail++; $display("FAIL rst_prefix got %h want 006b", d);
        end
    endtask

    task automatic test_typematic();
        logic [15:0] d;
        logic [15:0] exp_q [5];
        int          n_exp;
`ifdef TYPEMATIC_FILTER_EN
        exp_q[0] = 16'h001C; exp_q[1] = 16'h021C; exp_q[2] = 16'h001C;
        exp_q[3] = 16'h0000; exp_q[4] = 16'h0000;
        n_exp = 3;
`else
        exp_q[0] = 16'h001C; exp_q[1] = 16'h001C; exp_q[2] = 16'h001C;
        exp_q[3] = 16'h021C; exp_q[4] = 16'h001C;
        n_exp = 5;
`endif
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        cpu_read(1'b1, d);
        n_checks++;
        if (d[15:8] !== 8'(n_exp)) begin
            n_fail++; $display("FAIL tm_count got %0d want %0d", d[15:8], n_exp);
        end
        for (int i = 0; i < n_exp; i++) begin
            cpu_read(1'b0, d);
            n_checks++;
            if (d !== exp_q[i]) begin
                n_fail++; $display("FAIL tm_event%0d got %h want %h", i, d, exp_q[i]);
            end
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b0;
        u_if.code_in    = 8'h00;
        u_if.code_valid = 1'b0;
        u_if.cpu_rdn    = 1'b1;
        u_if.cpu_sel    = 1'b0;
        repeat (3) @(negedge fclk);
        rst = 1'b1;
        @(negedge fclk);

        test_reset();
        test_make_break();
        test_ext_break();
        test_overflow();
        test_full_pop_push();
        test_empty_pop_push();
        test_prefix_discard();
        test_reset_mid_prefix();
        test_typematic();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
